// File: rtl/armleocpu_defines.sv
// Shared constants for the writeback stage: load funct3 encodings and FSM states.
package armleocpu_defines;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_LOAD_WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/armleocpu_load_formatter.sv
// Combinational load data formatter: byte/half/word lane extraction with
// sign/zero extension, flagging unknown funct3 and misaligned accesses.
module armleocpu_load_formatter
   import armleocpu_defines::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  load_type_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] data_o,
   output logic        illegal_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      case (addr_lo_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o    = '0;
      illegal_o = 1'b0;
      case (load_type_i)
         LOAD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LOAD_LBU: data_o = {24'd0, byte_sel};
         LOAD_LH: begin
            data_o    = {{16{half_sel[15]}}, half_sel};
            illegal_o = addr_lo_i[0];
         end
         LOAD_LHU: begin
            data_o    = {16'd0, half_sel};
            illegal_o = addr_lo_i[0];
         end
         LOAD_LW: begin
            data_o    = rdata_i;
            illegal_o = |addr_lo_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/armleocpu_writeback.sv
// Writeback stage: registers ALU results, waits on variable-latency loads,
// formats load data and drives the single regfile write port.
module armleocpu_writeback
   import armleocpu_defines::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_rd_write,
   input  logic [4:0]  in_rd_addr,
   input  logic [31:0] in_result,
   input  logic [2:0]  in_load_type,
   input  logic [1:0]  in_addr_lo,

   input  logic        mem_rvalid,
   input  logic        mem_rerror,
   input  logic [31:0] mem_rdata,

   output logic        pending_valid,
   output logic [4:0]  pending_rd,
   output logic        wb_load_fault,

   output logic        rd_write,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_wdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   wb_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       cap_rd_q, cap_rd_d;
   logic             cap_wr_q, cap_wr_d;
   logic [2:0]       cap_type_q, cap_type_d;
   logic [1:0]       cap_lo_q, cap_lo_d;
   logic             rd_write_q, rd_write_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic [31:0]      rd_wdata_q, rd_wdata_d;
   logic             fault_q, fault_d;

   logic [31:0]      fmt_data;
   logic             fmt_illegal;
   logic             timeout_hit;

   armleocpu_load_formatter u_fmt (
      .rdata_i     (mem_rdata),
      .load_type_i (cap_type_q),
      .addr_lo_i   (cap_lo_q),
      .data_o      (fmt_data),
      .illegal_o   (fmt_illegal)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   assign in_ready      = (state_q == WB_IDLE);
   assign pending_valid = (state_q == WB_LOAD_WAIT);
   assign pending_rd    = pending_valid ? cap_rd_q : 5'd0;
   assign wb_load_fault = fault_q;
   assign rd_write      = rd_write_q;
   assign rd_addr       = rd_addr_q;
   assign rd_wdata      = rd_wdata_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_rd_d   = cap_rd_q;
      cap_wr_d   = cap_wr_q;
      cap_type_d = cap_type_q;
      cap_lo_d   = cap_lo_q;
      rd_write_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      rd_wdata_d = rd_wdata_q;
      fault_d    = 1'b0;

      case (state_q)
         WB_IDLE: begin
            // Responses arriving here (e.g. after a timeout) are stale and dropped.
            if (in_valid) begin
               if (in_is_load) begin
                  state_d    = WB_LOAD_WAIT;
                  cnt_d      = '0;
                  cap_rd_d   = in_rd_addr;
                  cap_wr_d   = in_rd_write;
                  cap_type_d = in_load_type;
                  cap_lo_d   = in_addr_lo;
               end else begin
                  rd_write_d = in_rd_write && (in_rd_addr != 5'd0);
                  rd_addr_d  = in_rd_addr;
                  rd_wdata_d = in_result;
               end
            end
         end
         WB_LOAD_WAIT: begin
            if (mem_rvalid) begin
               state_d = WB_IDLE;
               cnt_d   = '0;
               if (mem_rerror || fmt_illegal) begin
                  fault_d = 1'b1;
               end else begin
                  rd_write_d = cap_wr_q && (cap_rd_q != 5'd0);
                  rd_addr_d  = cap_rd_q;
                  rd_wdata_d = fmt_data;
               end
            end else if (timeout_hit) begin
               state_d = WB_IDLE;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WB_IDLE;
         cnt_q      <= '0;
         cap_rd_q   <= '0;
         cap_wr_q   <= 1'b0;
         cap_type_q <= '0;
         cap_lo_q   <= '0;
         rd_write_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_wdata_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_rd_q   <= cap_rd_d;
         cap_wr_q   <= cap_wr_d;
         cap_type_q <= cap_type_d;
         cap_lo_q   <= cap_lo_d;
         rd_write_q <= rd_write_d;
         rd_addr_q  <= rd_addr_d;
         rd_wdata_q <= rd_wdata_d;
         fault_q    <= fault_d;
      end
   end

endmodule

// File: tb/tb_armleocpu_writeback.sv
// Bench for armleocpu_writeback: directed vector table, reset/late-response
// sequences, and random traffic compared against a transaction-level model.
module tb_armleocpu_writeback;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_is_load, in_rd_write;
   logic [4:0]  in_rd_addr;
   logic [31:0] in_result;
   logic [2:0]  in_load_type;
   logic [1:0]  in_addr_lo;
   logic        mem_rvalid, mem_rerror;
   logic [31:0] mem_rdata;
   logic        pending_valid, wb_load_fault, rd_write;
   logic [4:0]  pending_rd, rd_addr;
   logic [31:0] rd_wdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   armleocpu_writeback #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
      .in_rd_write(in_rd_write), .in_rd_addr(in_rd_addr), .in_result(in_result),
      .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
      .mem_rvalid(mem_rvalid), .mem_rerror(mem_rerror), .mem_rdata(mem_rdata),
      .pending_valid(pending_valid), .pending_rd(pending_rd),
      .wb_load_fault(wb_load_fault),
      .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
   );

   // Reference formatting from arithmetic on the word: {bad, data}.
   function automatic logic [32:0] ref_fmt(input logic [2:0] t, input logic [1:0] lo,
                                           input logic [31:0] w);
      int unsigned v;
      logic b;
      v = 0;
      b = 1'b0;
      case (t)
         3'd0, 3'd4: begin
            v = (w >> (int'(lo) * 8)) & 32'hFF;
            if (t == 3'd0 && v >= 128) v = v - 256;
         end
         3'd1, 3'd5: begin
            b = (int'(lo) % 2) != 0;
            v = (w >> ((int'(lo) / 2) * 16)) & 32'hFFFF;
            if (t == 3'd1 && v >= 32768) v = v - 65536;
         end
         3'd2: begin
            b = lo != 2'd0;
            v = w;
         end
         default: b = 1'b1;
      endcase
      return {b, v[31:0]};
   endfunction

   // Transaction-level model.
   logic        m_busy, m_wr, e_write, e_fault;
   int          m_cnt;
   logic [4:0]  m_rd, e_addr;
   logic [2:0]  m_t;
   logic [1:0]  m_lo;
   logic [31:0] e_wdata;
   logic [32:0] m_f;
   assign m_f = ref_fmt(m_t, m_lo, mem_rdata);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_cnt <= 0; m_rd <= '0; m_wr <= 1'b0; m_t <= '0; m_lo <= '0;
         e_write <= 1'b0; e_fault <= 1'b0; e_addr <= '0; e_wdata <= '0;
      end else begin
         e_write <= 1'b0;
         e_fault <= 1'b0;
         if (!m_busy) begin
            if (in_valid) begin
               if (in_is_load) begin
                  m_busy <= 1'b1; m_cnt <= 0; m_rd <= in_rd_addr; m_wr <= in_rd_write;
                  m_t <= in_load_type; m_lo <= in_addr_lo;
               end else begin
                  e_write <= in_rd_write && in_rd_addr != 0;
                  e_addr  <= in_rd_addr;
                  e_wdata <= in_result;
               end
            end
         end else if (mem_rvalid) begin
            m_busy <= 1'b0;
            if (mem_rerror || m_f[32]) e_fault <= 1'b1;
            else begin
               e_write <= m_wr && m_rd != 0;
               e_addr  <= m_rd;
               e_wdata <= m_f[31:0];
            end
         end else if (m_cnt == TO - 1) begin
            m_busy  <= 1'b0;
            e_fault <= 1'b1;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("pending_valid", 32'(pending_valid), 32'(m_busy));
      check("pending_rd", 32'(pending_rd), m_busy ? 32'(m_rd) : 32'd0);
      check("rd_write", 32'(rd_write), 32'(e_write));
      check("wb_load_fault", 32'(wb_load_fault), 32'(e_fault));
      check("rd_addr", 32'(rd_addr), 32'(e_addr));
      check("rd_wdata", rd_wdata, e_wdata);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   typedef struct {
      logic        is_load;
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [2:0]  t;
      logic [1:0]  lo;
      int          lat;
      logic        resp;
      logic [31:0] rdata;
      logic        rerr;
      logic        ex_wr;
      logic        ex_fault;
      logic [31:0] ex_wdata;
   } vec_t;

   vec_t vt[14];

   initial begin
      vt[0]  = '{1'b0, 1'b1, 5'd1,  32'hFF00FF00, 3'd0, 2'd0, 0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFF00FF00};
      vt[1]  = '{1'b0, 1'b1, 5'd0,  32'h12345678, 3'd0, 2'd0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
      vt[2]  = '{1'b0, 1'b0, 5'd5,  32'hCAFEF00D, 3'd0, 2'd0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
      vt[3]  = '{1'b1, 1'b1, 5'd7,  32'h0,        3'd0, 2'd2, 3, 1'b1, 32'h00800000, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80};
      vt[4]  = '{1'b1, 1'b1, 5'd8,  32'h0,        3'd5, 2'd2, 1, 1'b1, 32'h8001ABCD, 1'b0, 1'b1, 1'b0, 32'h00008001};
      vt[5]  = '{1'b1, 1'b1, 5'd9,  32'h0,        3'd1, 2'd1, 0, 1'b1, 32'h8001ABCD, 1'b0, 1'b0, 1'b1, 32'h0};
      vt[6]  = '{1'b1, 1'b1, 5'd10, 32'h0,        3'd2, 2'd0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
      vt[7]  = '{1'b1, 1'b1, 5'd11, 32'h0,        3'd2, 2'd2, 2, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
      vt[8]  = '{1'b1, 1'b1, 5'd12, 32'h0,        3'd4, 2'd3, 0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h00000080};
      vt[9]  = '{1'b1, 1'b1, 5'd13, 32'h0,        3'd3, 2'd0, 0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h0};
      vt[10] = '{1'b1, 1'b1, 5'd14, 32'h0,        3'd0, 2'd0, 1, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b1, 32'h0};
      vt[11] = '{1'b1, 1'b1, 5'd15, 32'h0,        3'd0, 2'd0, 4, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
      vt[12] = '{1'b1, 1'b1, 5'd16, 32'h0,        3'd1, 2'd2, 3, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'hFFFF8000};
      vt[13] = '{1'b1, 1'b1, 5'd0,  32'h0,        3'd2, 2'd0, 0, 1'b1, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 32'h0};

      rst_n = 1'b0;
      in_valid = 1'b0; in_is_load = 1'b0; in_rd_write = 1'b0; in_rd_addr = '0;
      in_result = '0; in_load_type = '0; in_addr_lo = '0;
      mem_rvalid = 1'b0; mem_rerror = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("reset rd_write", 32'(rd_write), 32'd0);
      check("reset rd_wdata", rd_wdata, 32'd0);
      check("reset fault", 32'(wb_load_fault), 32'd0);
      check("reset pending", 32'(pending_valid), 32'd0);
      check_all();
      rst_n = 1'b1;
      cyc();

      // Directed vectors.
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1; in_is_load = vt[i].is_load; in_rd_write = vt[i].wr;
         in_rd_addr = vt[i].rd; in_result = vt[i].res;
         in_load_type = vt[i].t; in_addr_lo = vt[i].lo;
         cyc();
         in_valid = 1'b0;
         if (vt[i].is_load) begin
            for (int k = 0; k < vt[i].lat; k++) begin
               check($sformatf("v%0d pending", i), 32'(pending_valid), 32'd1);
               check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd0);
               cyc();
            end
            if (vt[i].resp) begin
               mem_rvalid = 1'b1; mem_rdata = vt[i].rdata; mem_rerror = vt[i].rerr;
               cyc();
               mem_rvalid = 1'b0; mem_rerror = 1'b0;
            end
         end
         check($sformatf("v%0d wr", i), 32'(rd_write), 32'(vt[i].ex_wr));
         check($sformatf("v%0d fault", i), 32'(wb_load_fault), 32'(vt[i].ex_fault));
         check($sformatf("v%0d ready", i), 32'(in_ready), 32'd1);
         if (vt[i].ex_wr) check($sformatf("v%0d wdata", i), rd_wdata, vt[i].ex_wdata);
         if (vt[i].ex_wr || !vt[i].is_load)
            check($sformatf("v%0d addr", i), 32'(rd_addr), 32'(vt[i].rd));
         if (i == 11) begin
            // Response after timeout must be ignored.
            mem_rvalid = 1'b1; mem_rdata = 32'h7F;
            cyc();
            mem_rvalid = 1'b0;
            check("late resp wr", 32'(rd_write), 32'd0);
            check("late resp fault", 32'(wb_load_fault), 32'd0);
         end
      end

      // Reset asserted mid-load.
      in_valid = 1'b1; in_is_load = 1'b1; in_rd_write = 1'b1; in_rd_addr = 5'd9;
      in_load_type = 3'd2; in_addr_lo = 2'd0;
      cyc();
      in_valid = 1'b0;
      cyc();
      check("midload pending", 32'(pending_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst pending_valid", 32'(pending_valid), 32'd0);
      check("rst pending_rd", 32'(pending_rd), 32'd0);
      check("rst rd_addr", 32'(rd_addr), 32'd0);
      check("rst rd_wdata", rd_wdata, 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
      cyc();
      mem_rvalid = 1'b0;
      check("post-rst wr", 32'(rd_write), 32'd0);
      check("post-rst fault", 32'(wb_load_fault), 32'd0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         in_valid     = $urandom_range(0, 1) == 1;
         in_is_load   = $urandom_range(0, 1) == 1;
         in_rd_write  = $urandom_range(0, 7) != 0;
         in_rd_addr   = 5'($urandom_range(0, 31));
         in_result    = $urandom;
         in_load_type = 3'($urandom_range(0, 7));
         in_addr_lo   = 2'($urandom_range(0, 3));
         mem_rvalid   = $urandom_range(0, 2) == 0;
         mem_rerror   = $urandom_range(0, 11) == 0;
         mem_rdata    = $urandom;
         cyc();
      end
      in_valid = 1'b0; mem_rvalid = 1'b0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/armleocpu_writeback.md
Name: armleocpu_writeback

Overview:
- Final pipeline stage, directly upstream of armleocpu_regfile; sole driver of its rd_write/rd_addr/rd_wdata write port.
- Accepts ALU results and load requests from the memory stage, waits for variable-latency load data, and formats it (byte/half extraction, sign/zero extension).
- Presents one registered write per cycle and exposes the pending load destination for hazard detection upstream.

Parameters:
- TIMEOUT_CYCLES, 0, load-response watchdog in cycles; 0 disables it.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  memory stage presents an instruction result
- in_ready  out  1  writeback accepts this cycle
- in_is_load  in  1  1 = load awaiting mem response, 0 = in_result is final
- in_rd_write  in  1  instruction writes rd
- in_rd_addr  in  5  destination register
- in_result  in  32  ALU/CSR result (ignored for loads)
- in_load_type  in  3  load funct3
- in_addr_lo  in  2  load address bits [1:0]
- mem_rvalid  in  1  load data/response valid
- mem_rerror  in  1  bus error on response, qualified by mem_rvalid
- mem_rdata  in  32  raw aligned word
- pending_valid  out  1  load outstanding
- pending_rd  out  5  rd of outstanding load
- wb_load_fault  out  1  one-cycle pulse: bus error, illegal/misaligned type, or timeout
- rd_write  out  1  regfile write enable
- rd_addr  out  5  regfile write address
- rd_wdata  out  32  regfile write data

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_write=0, rd_addr=0, rd_wdata=0, wb_load_fault=0, pending_valid=0, pending_rd=0, timeout counter=0.
- Handshake: transfer when in_valid && in_ready; in_ready=1 in IDLE, 0 in LOAD_WAIT (combinational from state).
- States IDLE, LOAD_WAIT.
- IDLE, non-load accept: next cycle rd_write=in_rd_write && (in_rd_addr!=0), rd_addr=in_rd_addr, rd_wdata=in_result. Latency 1.
- IDLE, load accept: capture rd/write/type/addr_lo; go LOAD_WAIT; rd_write=0 next cycle.
- IDLE, mem_rvalid: ignored.
- LOAD_WAIT: pending_valid=1, pending_rd=captured rd; counter increments each cycle.
- LOAD_WAIT, mem_rvalid: go IDLE. If mem_rerror, or type/alignment illegal: rd_write=0, wb_load_fault=1 next cycle. Otherwise rd_write=captured write && rd!=0, rd_wdata=formatted data, next cycle. in_ready=1 in that same next cycle (back-to-back allowed).
- Timeout: TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without mem_rvalid -> IDLE, fault pulse, no write. A response arriving later is ignored.
- Formatting by type, s=addr_lo*8:
  - 000 LB: sign-extend mem_rdata[s+7:s].
  - 100 LBU: zero-extend mem_rdata[s+7:s].
  - 001 LH / 101 LHU: half at addr_lo[1]*16, sign/zero extended; addr_lo[0]=1 -> fault.
  - 010 LW: whole word; addr_lo!=0 -> fault.
  - Any other type -> fault.
- rd_write and wb_load_fault are single-cycle pulses; rd_addr/rd_wdata hold their last value when rd_write=0.
- x0: write suppressed, rd_addr still updated.
- rst_n asserted mid-load: pending load dropped, no write, no fault.

Decomposition:
- armleocpu_defines package: load funct3 constants (LB/LH/LW/LBU/LHU), writeback state enum.
- Sub-module armleocpu_load_formatter (combinational): rdata, type, addr_lo -> formatted data, illegal flag.

Test Plan:
- ALU write: in_result=32'hFF00FF00, rd=1, rd_write=1 -> next cycle rd_write=1, rd_addr=1, rd_wdata=FF00FF00; regfile rs1_addr=1 reads FF00FF00 one cycle later.
- x0 suppression: rd=0, in_result=32'h12345678 -> rd_write=0, rd_addr=0.
- LB, addr_lo=2, mem_rdata=32'h00800000 after 3 cycles -> pending_valid=1, pending_rd=rd and in_ready=0 for 3 cycles; then rd_wdata=FFFFFF80, in_ready=1.
- LHU addr_lo=2, rdata=32'h8001ABCD -> 00008001; LH addr_lo=1 -> fault pulse, no write.
- mem_rerror=1 on response -> wb_load_fault=1 for one cycle, rd_write=0. With TIMEOUT_CYCLES=4 and no response -> fault after 4 LOAD_WAIT cycles, state IDLE.
- rst_n pulled low during LOAD_WAIT -> all outputs 0 immediately; a later mem_rvalid causes no write.
